// File: rtl/exec_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// exec_ctrl_pkg
// Shared types and constants for the execution controller.
//   state_t    : controller state (IDLE, RUN, PRINT, DONE, FAULT)
//   COL_*      : 6-bit RGB LED patterns {r,g,b,r,g,b} shown in each state
// ---------------------------------------------------------------------------
package exec_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    PRINT,
    DONE,
    FAULT
  } state_t;

  localparam logic [5:0] COL_IDLE  = 6'b001_001;  // blue
  localparam logic [5:0] COL_RUN   = 6'b011_011;  // cyan
  localparam logic [5:0] COL_PRINT = 6'b101_101;  // magenta
  localparam logic [5:0] COL_DONE  = 6'b010_010;  // green
  localparam logic [5:0] COL_FAULT = 6'b100_100;  // red

  localparam logic [31:0] RUN_CYCLES_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/exec_ctrl_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Debounces one already-synchronized push-button and emits a one-cycle pulse
// when the accepted level flips from 0 to 1.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   btn   : raw (synchronized, possibly bouncing) button level
//   pulse : one-cycle press pulse
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  // The flip happens on the sample that would make the count reach DEB_CYCLES,
  // so the stored count only ever needs to reach DEB_CYCLES-1.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (btn != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= btn;
          r_cnt   <= '0;
          r_pulse <= btn;  // only a 0->1 flip produces a pulse
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign pulse = r_pulse;

endmodule

// File: rtl/exec_ctrl.sv
// ---------------------------------------------------------------------------
// exec_ctrl
// Execution controller for the RISC-V core: debounces start/resume buttons,
// sequences the core through IDLE/RUN/PRINT/DONE/FAULT, drives core reset and
// clock-enable, latches print values for the display and shows the state on
// the RGB LEDs. All outputs are registered.
//   clk, rst        : clock, synchronous active-high reset
//   start_btn       : start button (synchronized, may bounce)
//   resume_btn      : resume button (synchronized, may bounce)
//   print_req/data  : core print request (held until print_ack) and value
//   exit_req, fault : core exit ecall / fault levels
//   core_rst        : reset to the core
//   core_en         : core clock-enable (0 stalls the core)
//   print_ack       : one-cycle print acknowledge
//   color_leds      : two RGB LEDs {r,g,b,r,g,b}
//   display         : last printed value (low 16 bits)
//   run_cycles      : saturating count of cycles with core_en=1
// ---------------------------------------------------------------------------
module exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        resume_btn,
  input  logic        print_req,
  input  logic [31:0] print_data,
  input  logic        exit_req,
  input  logic        fault,
  output logic        core_rst,
  output logic        core_en,
  output logic        print_ack,
  output logic [5:0]  color_leds,
  output logic [15:0] display,
  output logic [31:0] run_cycles
);

  // Button index 0 = start, 1 = resume.
  logic [1:0] w_btn;
  logic [1:0] w_pulse;
  logic       w_start_p;
  logic       w_resume_p;
  logic       w_unused_print_hi;

  assign w_btn             = {resume_btn, start_btn};
  assign w_start_p         = w_pulse[0];
  assign w_resume_p        = w_pulse[1];
  assign w_unused_print_hi = ^print_data[31:16];  // only the low half is displayed

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_deb
      btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
        .clk  (clk),
        .rst  (rst),
        .btn  (w_btn[gi]),
        .pulse(w_pulse[gi])
      );
    end
  endgenerate

  state_t      r_state;
  logic        r_core_rst;
  logic        r_core_en;
  logic        r_print_ack;
  logic [5:0]  r_color;
  logic [15:0] r_display;
  logic [31:0] r_run_cycles;

  // Each transition writes the registered outputs of the state it enters,
  // so outputs always match r_state without a combinational decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_core_rst   <= 1'b1;
      r_core_en    <= 1'b0;
      r_print_ack  <= 1'b0;
      r_color      <= COL_IDLE;
      r_display    <= '0;
      r_run_cycles <= '0;
    end else begin
      r_print_ack <= 1'b0;
      if (r_core_en && (r_run_cycles != RUN_CYCLES_MAX)) begin
        r_run_cycles <= r_run_cycles + 32'd1;
      end

      unique case (r_state)
        IDLE: begin
          r_run_cycles <= '0;
          r_display    <= '0;
          if (w_start_p) begin
            r_state    <= RUN;
            r_core_rst <= 1'b0;
            r_core_en  <= 1'b1;
            r_color    <= COL_RUN;
          end
        end

        RUN: begin
          // Fixed priority: fault, then exit, then print.
          if (fault) begin
            r_state   <= FAULT;
            r_core_en <= 1'b0;
            r_color   <= COL_FAULT;
          end else if (exit_req) begin
            r_state   <= DONE;
            r_core_en <= 1'b0;
            r_color   <= COL_DONE;
          end else if (print_req) begin
            r_state   <= PRINT;
            r_core_en <= 1'b0;
            r_color   <= COL_PRINT;
            r_display <= print_data[15:0];
          end
        end

        PRINT: begin
          if (w_resume_p) begin
            r_state     <= RUN;
            r_core_en   <= 1'b1;
            r_print_ack <= 1'b1;  // high for the first RUN cycle only
            r_color     <= COL_RUN;
          end
        end

        DONE, FAULT: begin
          if (w_start_p) begin
            // Back to IDLE with the core held in reset; a further start reruns.
            r_state      <= IDLE;
            r_core_rst   <= 1'b1;
            r_core_en    <= 1'b0;
            r_color      <= COL_IDLE;
            r_display    <= '0;
            r_run_cycles <= '0;
          end
        end

        default: begin
          r_state      <= IDLE;
          r_core_rst   <= 1'b1;
          r_core_en    <= 1'b0;
          r_color      <= COL_IDLE;
          r_display    <= '0;
          r_run_cycles <= '0;
        end
      endcase
    end
  end

  assign core_rst   = r_core_rst;
  assign core_en    = r_core_en;
  assign print_ack  = r_print_ack;
  assign color_leds = r_color;
  assign display    = r_display;
  assign run_cycles = r_run_cycles;

endmodule

// File: tb/tb_exec_ctrl.sv
// ---------------------------------------------------------------------------
// tb_exec_ctrl
// Self-checking bench for exec_ctrl (DEB_CYCLES=4): directed scenarios plus a
// randomized phase, all outputs compared every cycle with a behavioural model.
// ---------------------------------------------------------------------------
module tb_exec_ctrl;

  localparam int DEB = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PRINT = 2, M_DONE = 3, M_FAULT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_btn, resume_btn, print_req, exit_req, fault;
  logic [31:0] print_data;
  logic        core_rst, core_en, print_ack;
  logic [5:0]  color_leds;
  logic [15:0] display;
  logic [31:0] run_cycles;

  exec_ctrl #(.DEB_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_btn (start_btn),
    .resume_btn(resume_btn),
    .print_req (print_req),
    .print_data(print_data),
    .exit_req  (exit_req),
    .fault     (fault),
    .core_rst  (core_rst),
    .core_en   (core_en),
    .print_ack (print_ack),
    .color_leds(color_leds),
    .display   (display),
    .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_mode;
  int          m_streak [2];   // consecutive samples disagreeing with the accepted level
  bit          m_level  [2];
  bit          m_press  [2];   // press seen on the previous edge, acts on this edge
  bit          m_ack;
  logic [15:0] m_disp;
  logic [31:0] m_cycles;

  function automatic logic [5:0] color_of(int mode);
    case (mode)
      M_IDLE:  return 6'b001_001;
      M_RUN:   return 6'b011_011;
      M_PRINT: return 6'b101_101;
      M_DONE:  return 6'b010_010;
      default: return 6'b100_100;
    endcase
  endfunction

  function automatic string name_of(int mode);
    case (mode)
      M_IDLE:  return "IDLE";
      M_RUN:   return "RUN";
      M_PRINT: return "PRINT";
      M_DONE:  return "DONE";
      default: return "FAULT";
    endcase
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_ack = 0; m_disp = '0; m_cycles = '0;
    for (int b = 0; b < 2; b++) begin
      m_streak[b] = 0; m_level[b] = 0; m_press[b] = 0;
    end
  endtask

  task automatic model_step();
    bit btn [2];
    bit was_running;
    if (rst) begin
      model_reset();
      return;
    end
    was_running = (m_mode == M_RUN);
    m_ack = 0;
    if (was_running && m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
    case (m_mode)
      M_IDLE: begin
        m_cycles = 0; m_disp = 0;
        if (m_press[0]) m_mode = M_RUN;
      end
      M_RUN: begin
        if (fault)          m_mode = M_FAULT;
        else if (exit_req)  m_mode = M_DONE;
        else if (print_req) begin m_mode = M_PRINT; m_disp = print_data[15:0]; end
      end
      M_PRINT: if (m_press[1]) begin m_mode = M_RUN; m_ack = 1; end
      default: if (m_press[0]) begin m_mode = M_IDLE; m_disp = 0; m_cycles = 0; end
    endcase
    btn[0] = start_btn; btn[1] = resume_btn;
    for (int b = 0; b < 2; b++) begin
      m_press[b] = 0;
      if (btn[b] != m_level[b]) begin
        m_streak[b]++;
        if (m_streak[b] == DEB) begin
          m_level[b]  = btn[b];
          m_streak[b] = 0;
          m_press[b]  = btn[b];
        end
      end else begin
        m_streak[b] = 0;
      end
    end
  endtask

  task automatic compare_all();
    check_val("core_rst",   32'(core_rst),   32'(m_mode == M_IDLE));
    check_val("core_en",    32'(core_en),    32'(m_mode == M_RUN));
    check_val("print_ack",  32'(print_ack),  32'(m_ack));
    check_val("color_leds", 32'(color_leds), 32'(color_of(m_mode)));
    check_val("display",    32'(display),    32'(m_disp));
    check_val("run_cycles", run_cycles,      m_cycles);
  endtask

  // One clock: model advances on the edge, outputs compared at the negedge.
  task automatic tick();
    int prev;
    prev = m_mode;
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    if (prev != m_mode)
      $display("cycle %0d: state %s -> %s display=0x%0h run_cycles=%0d",
               cyc, name_of(prev), name_of(m_mode), m_disp, m_cycles);
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Clean press: held 8 cycles, released 8 cycles.
  task automatic press(input int which);
    if (which == 0) start_btn = 1; else resume_btn = 1;
    ticks(8);
    if (which == 0) start_btn = 0; else resume_btn = 0;
    ticks(8);
  endtask

  int hold_left [2];

  initial begin
    int fall_at;
    int acks;
    logic [31:0] frozen;

    rst = 1; start_btn = 0; resume_btn = 0; print_req = 0;
    print_data = '0; exit_req = 0; fault = 0;
    model_reset();
    @(negedge clk);
    tick();
    check_val("reset_color", 32'(color_leds), 32'h09);
    check_val("reset_core_rst", 32'(core_rst), 32'd1);
    rst = 0;
    ticks(2);

    // Bounce 1,0,1,0 then a 3-cycle high: below threshold, no start.
    start_btn = 1; tick(); start_btn = 0; tick();
    start_btn = 1; tick(); start_btn = 0; tick();
    start_btn = 1; ticks(3); start_btn = 0; ticks(6);
    check_val("bounce_no_start", 32'(core_rst), 32'd1);

    // Steady 20-cycle hold: one start, core_rst falls DEB+1 cycles after the rise.
    fall_at = 0;
    start_btn = 1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (fall_at == 0 && core_rst == 1'b0) fall_at = i;
    end
    check_val("start_latency", 32'(fall_at), 32'(DEB + 1));
    check_val("run_color", 32'(color_leds), 32'h1B);
    check_val("run_count", run_cycles, 32'd15);
    start_btn = 0; ticks(8);

    // Print request.
    print_req = 1; print_data = 32'h0001_0037;
    tick();
    check_val("print_display", 32'(display), 32'h37);
    check_val("print_color", 32'(color_leds), 32'h2D);
    frozen = run_cycles;
    ticks(3);
    check_val("print_frozen", run_cycles, frozen);
    resume_btn = 1;
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (print_ack) begin
        acks++;
        check_val("ack_core_en", 32'(core_en), 32'd1);
        print_req = 0;
      end
    end
    check_val("ack_cycles", 32'(acks), 32'd1);
    resume_btn = 0; print_req = 0; ticks(8);

    // fault + exit + print together: fault wins, display unchanged, no ack.
    fault = 1; exit_req = 1; print_req = 1; print_data = 32'h0000_BEEF;
    tick();
    fault = 0; exit_req = 0; print_req = 0;
    check_val("fault_color", 32'(color_leds), 32'h24);
    check_val("fault_display", 32'(display), 32'h37);
    check_val("fault_no_ack", 32'(print_ack), 32'd0);
    tick();
    press(0);
    check_val("fault_to_idle", 32'(core_rst), 32'd1);
    check_val("idle_cycles_clr", run_cycles, 32'd0);
    press(0);
    check_val("rerun", 32'(core_en), 32'd1);

    // exit -> DONE, resume ignored, start -> IDLE.
    exit_req = 1; tick(); exit_req = 0;
    check_val("done_color", 32'(color_leds), 32'h12);
    press(1);
    check_val("done_resume_ignored", 32'(color_leds), 32'h12);
    press(0);
    check_val("done_to_idle", 32'(core_rst), 32'd1);

    // rst while in PRINT with resume debounce in progress.
    press(0);
    print_req = 1; print_data = 32'h1234_5678; tick();
    resume_btn = 1; ticks(2);
    rst = 1; tick(); rst = 0;
    check_val("rst_display", 32'(display), 32'd0);
    check_val("rst_color", 32'(color_leds), 32'h09);
    print_req = 0; resume_btn = 0; tick();
    press(1);
    check_val("rst_resume_ignored", 32'(core_rst), 32'd1);

    // Randomized phase.
    hold_left[0] = 0; hold_left[1] = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      for (int b = 0; b < 2; b++) begin
        if (hold_left[b] == 0) begin
          hold_left[b] = $urandom_range(1, 10);
          if (b == 0) start_btn = 1'($urandom_range(0, 1));
          else        resume_btn = 1'($urandom_range(0, 1));
        end
        hold_left[b]--;
      end
      if (m_mode == M_IDLE || m_ack) print_req = 0;
      else if (!print_req && m_mode == M_RUN && $urandom_range(0, 19) == 0) begin
        print_req  = 1;
        print_data = $urandom;
      end
      exit_req = ($urandom_range(0, 149) == 0);
      fault    = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exec_ctrl.md
# exec_ctrl

Execution controller for the RISC-V core in the SoC top level. It turns the raw start/resume push-buttons into debounced one-cycle commands and sequences the core through idle, run, print-pause, done and fault. It drives the core's reset and clock-enable, latches integer print values for the 7-segment display, and encodes the state on the RGB color LEDs. It sits between the board I/O (after the 2-FF synchronizers) and the core.

## Interface
Parameters:
- DEB_CYCLES, 50000: consecutive stable samples required to accept a button press or release (0.5 ms at 100 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; synchronous, active-high.
- start_btn  in  1  start button, already synchronized, may bounce.
- resume_btn  in  1  resume button, already synchronized, may bounce.
- print_req  in  1  core requests an integer print; held high until print_ack.
- print_data  in  32  integer to print; valid while print_req is high.
- exit_req  in  1  core executed the exit ecall (level).
- fault  in  1  core illegal instruction or misaligned access (level).
- core_rst  out  1  reset to the core.
- core_en  out  1  core clock-enable / stall; 0 freezes the core.
- print_ack  out  1  one-cycle acknowledge of a print request.
- color_leds  out  6  two RGB LEDs {r,g,b,r,g,b}.
- display  out  16  value shown on the display.
- run_cycles  out  32  count of cycles with core_en=1.

## Operation
- One btn_debounce instance per button.
  - The per-button counter counts consecutive samples that differ from the accepted level and clears on any match.
  - When the count reaches DEB_CYCLES, the accepted level flips.
  - A 0->1 flip emits a one-cycle pulse (start_p / resume_p). A 1->0 flip emits nothing.
  - Holding a button produces exactly one pulse.
- FSM states, with core_rst / core_en / color_leds:
  - IDLE: 1 / 0 / 001_001 (blue).
  - RUN: 0 / 1 / 011_011 (cyan).
  - PRINT: 0 / 0 / 101_101 (magenta).
  - DONE: 0 / 0 / 010_010 (green).
  - FAULT: 0 / 0 / 100_100 (red).
- Transitions:
  - IDLE --start_p--> RUN.
  - RUN: fault > exit_req > print_req (fixed priority).
    - fault -> FAULT.
    - exit_req -> DONE.
    - print_req -> PRINT; display <= print_data[15:0] on the same edge.
  - PRINT --resume_p--> RUN; print_ack=1 for exactly the first RUN cycle.
  - DONE or FAULT --start_p--> IDLE. A further start_p is needed to rerun (the program restarts from reset).
- Ignored pulses:
  - start_p in RUN and PRINT.
  - resume_p in IDLE, RUN, DONE and FAULT.
  - print_req and exit_req outside RUN.
- Simultaneous start_p and resume_p: only the pulse meaningful in the current state acts.
- run_cycles:
  - Cleared while in IDLE.
  - Increments each cycle core_en=1.
  - Saturates at 0xFFFF_FFFF (no wrap).
- display keeps its last value through DONE and FAULT, and clears in IDLE.

## Timing
- Reset values:
  - State IDLE.
  - core_rst=1, core_en=0, print_ack=0.
  - color_leds=001_001, display=0, run_cycles=0.
  - Debounce counters 0, accepted levels 0.
- All outputs are Moore outputs decoded from registered state/data; there is no combinational input-to-output path.
- Button latency:
  - The pulse is high in the cycle after the DEB_CYCLES-th consecutive high sample.
  - The state changes on the next edge, so core_rst falls DEB_CYCLES+1 cycles after a clean rising edge.
- Print sampled at edge N: state=PRINT and core_en=0 from cycle N+1.
  - The core sees core_en=1 during the cycle print_req first rises.
  - The core must hold print_req and print_data, and must not retire the ecall, until print_ack.
- resume_p at cycle M: core_en=1 and print_ack=1 in cycle M+1; print_ack=0 at M+2.
  - The core must drop print_req in the cycle it sees print_ack.
- rst mid-operation: everything returns to reset values on the next edge, including a pending print and debounce progress.

## Structure
- exec_ctrl_pkg holds:
  - typedef enum logic [2:0] state_t {IDLE, RUN, PRINT, DONE, FAULT}.
  - 6-bit color constants COL_IDLE, COL_RUN, COL_PRINT, COL_DONE, COL_FAULT.
- Sub-module btn_debounce (parameter DEB_CYCLES; ports clk, rst, btn, pulse), instantiated twice.
- Counter width is $clog2(DEB_CYCLES+1).

## Test plan
All scenarios use DEB_CYCLES=4.
- Reset, then start_btn high for 20 cycles: exactly one start_p. core_rst falls 5 cycles after the rise. color 011_011, core_en=1, run_cycles counting.
- Bounce 1,0,1,0 at one cycle each, then a steady 3-cycle high: no pulse and no state change. Followed by a steady 10-cycle high: one pulse.
- In RUN, print_req=1 with print_data=0x0001_0037:
  - Next cycle: display=0x0037, color 101_101, core_en=0, run_cycles frozen.
  - resume press: print_ack high exactly one cycle, core_en=1.
- In RUN, fault=1, exit_req=1 and print_req=1 in the same cycle: FAULT (100_100), no ack, display unchanged. Then start press -> IDLE (core_rst=1, run_cycles=0); second start -> RUN.
- In RUN, exit_req=1: DONE (010_010), core_en=0. resume press has no effect; start press -> IDLE.
- rst asserted one cycle while in PRINT: all outputs at reset values on the next edge, and a later resume press does nothing.
